// File: rtl/exc_pkg.sv
// Shared types and constants for the ALU exception sequencer.
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_REDIRECT = 3'd2,
    S_HANDLER  = 3'd3,
    S_RETURN   = 3'd4,
    S_HALT     = 3'd5
  } exc_state_t;

  localparam logic [3:0] CAUSE_NONE  = 4'd0;
  localparam logic [3:0] CAUSE_OVF   = 4'd1;
  localparam logic [3:0] CAUSE_RANGE = 4'd2;
  localparam logic [3:0] CAUSE_ALIGN = 4'd3;

  localparam int BIT_OVF   = 6;
  localparam int BIT_RANGE = 3;
  localparam int BIT_ALIGN = 2;

  localparam int CNT_W = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/exc_cause_encoder.sv
// Priority encoder from EX-stage ALU flags to a fault indication and cause code.
module exc_cause_encoder
  import exc_pkg::*;
(
  input  logic [7:0] alu_status,
  output logic       any_fault,
  output logic [3:0] cause
);

  logic unused_bits;
  assign unused_bits = ^{alu_status[7], alu_status[5:4], alu_status[1:0]};

  assign any_fault = alu_status[BIT_OVF] | alu_status[BIT_RANGE] | alu_status[BIT_ALIGN];

  // Overflow outranks address range, which outranks misalignment.
  always_comb begin
    cause = CAUSE_NONE;
    if (alu_status[BIT_OVF])        cause = CAUSE_OVF;
    else if (alu_status[BIT_RANGE]) cause = CAUSE_RANGE;
    else if (alu_status[BIT_ALIGN]) cause = CAUSE_ALIGN;
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencer: gates data memory on a fault, flushes, vectors to the
// handler, returns on eret, and parks the core on a fault inside the handler.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int                PC_W         = 32,
  parameter logic [PC_W-1:0]   HANDLER_ADDR = 32'h0000_0080,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      alu_status,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            mem_read_req,
  input  logic            mem_write_req,
  input  logic            eret,
  output logic            mem_read,
  output logic            mem_write,
  output logic            flush,
  output logic            pc_redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] epc,
  output logic [3:0]      cause,
  output logic            in_handler,
  output logic            double_fault,
  output logic [7:0]      exc_count
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic       any_fault;
  logic [3:0] enc_cause;
  logic       fault;

  exc_cause_encoder u_enc (
    .alu_status (alu_status),
    .any_fault  (any_fault),
    .cause      (enc_cause)
  );

  assign fault = ex_valid & any_fault;

  exc_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             block;
  logic             take_epc;
  logic             take_cause;
  logic             set_dbl;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    in_handler  = 1'b0;
    block       = 1'b0;
    take_epc    = 1'b0;
    take_cause  = 1'b0;
    set_dbl     = 1'b0;
    unique case (state)
      S_IDLE: begin
        block = fault;
        if (fault) begin
          take_epc   = 1'b1;
          take_cause = 1'b1;
          cnt_nx     = FLUSH_LOAD;
          state_nx   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        block = 1'b1;
        if (cnt == '0) state_nx = S_REDIRECT;
        else           cnt_nx   = cnt - 1'b1;
      end
      S_REDIRECT: begin
        block       = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = HANDLER_ADDR;
        state_nx    = S_HANDLER;
      end
      S_HANDLER: begin
        in_handler = 1'b1;
        block      = fault;
        // A fault in the same cycle as eret takes precedence.
        if (fault) begin
          take_cause = 1'b1;
          set_dbl    = 1'b1;
          state_nx   = S_HALT;
        end else if (ex_valid && eret) begin
          state_nx = S_RETURN;
        end
      end
      S_RETURN: begin
        flush       = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = epc + PC_W'(4);
        state_nx    = S_IDLE;
      end
      S_HALT: begin
        flush = 1'b1;
        block = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      epc          <= '0;
      cause        <= CAUSE_NONE;
      exc_count    <= '0;
      double_fault <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (take_epc) epc <= ex_pc;
      if (take_cause) begin
        cause     <= enc_cause;
        exc_count <= sat_inc8(exc_count);
      end
      if (set_dbl) double_fault <= 1'b1;
    end
  end

  assign mem_read  = mem_read_req  & ~block;
  assign mem_write = mem_write_req & ~block;

  // Structural sanity: only one of redirect/handler at a time, and a parked
  // core must always report the double fault.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pc_redirect && in_handler))
        else $error("exception_ctrl: redirect while in handler");
      assert (state != S_HALT || double_fault)
        else $error("exception_ctrl: halted without double_fault");
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomized and directed bench for exception_ctrl against a phase-queue model.
module tb_exception_ctrl;

  localparam int FC = 2;
  localparam logic [31:0] HADDR = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  alu_status;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        mem_read_req, mem_write_req, eret;
  logic        mem_read, mem_write, flush, pc_redirect, in_handler, double_fault;
  logic [31:0] redirect_pc, epc;
  logic [3:0]  cause;
  logic [7:0]  exc_count;

  exception_ctrl #(.PC_W(32), .HANDLER_ADDR(HADDR), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .alu_status(alu_status), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .eret(eret), .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc(epc),
    .cause(cause), .in_handler(in_handler), .double_fault(double_fault),
    .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a queue of pending fixed-length phases (1 flush, 2 vector to
  // handler, 3 return) plus handler/halt flags.
  int          q[$];
  bit          m_handler, m_halted, m_dbl;
  logic [31:0] m_epc;
  logic [3:0]  m_cause;
  int          m_cnt;

  bit          e_flush, e_redir, e_inh, e_mr, e_mw;
  logic [31:0] e_rpc;

  function automatic logic [3:0] cause_of(input logic [7:0] s);
    if (s[6]) return 4'd1;
    if (s[3]) return 4'd2;
    if (s[2]) return 4'd3;
    return 4'd0;
  endfunction

  function automatic bit is_fault();
    return ex_valid && (alu_status[6] || alu_status[3] || alu_status[2]);
  endfunction

  task automatic model_edge();
    bit f;
    f = is_fault();
    if (reset) begin
      q.delete();
      m_handler = 0; m_halted = 0; m_dbl = 0;
      m_epc = 0; m_cause = 0; m_cnt = 0;
    end else if (q.size() > 0) begin
      int k;
      k = q.pop_front();
      if (k == 2) m_handler = 1;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_handler) begin
      if (f) begin
        m_halted = 1; m_handler = 0; m_dbl = 1;
        m_cause = cause_of(alu_status);
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (ex_valid && eret) begin
        m_handler = 0;
        q.push_back(3);
      end
    end else if (f) begin
      m_epc = ex_pc;
      m_cause = cause_of(alu_status);
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      repeat (FC) q.push_back(1);
      q.push_back(2);
    end
  endtask

  task automatic model_outputs();
    int k;
    bit idle, blk;
    k = (q.size() > 0) ? q[0] : 0;
    idle = (q.size() == 0) && !m_halted && !m_handler;
    blk = m_halted || k == 1 || k == 2 || (is_fault() && (idle || (m_handler && q.size() == 0)));
    e_flush = m_halted || k == 1 || k == 3;
    e_redir = (k == 2) || (k == 3);
    e_rpc   = (k == 2) ? HADDR : (k == 3) ? m_epc + 32'd4 : 32'd0;
    e_inh   = m_handler && q.size() == 0;
    e_mr    = mem_read_req && !blk;
    e_mw    = mem_write_req && !blk;
  endtask

  // Close the current cycle, then drive the next cycle's inputs.
  task automatic tick(input logic v, input logic [7:0] st, input logic [31:0] pc,
                      input logic rr, input logic rw, input logic er, input logic rs);
    @(posedge clk);
    model_edge();
    #1;
    ex_valid = v; alu_status = st; ex_pc = pc;
    mem_read_req = rr; mem_write_req = rw; eret = er; reset = rs;
    #1;
    model_outputs();
  endtask

  task automatic idle_tick();
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_handler(input string tag);
    for (int i = 0; i < 20 && !in_handler; i++) idle_tick();
    checks++;
    if (in_handler !== 1'b1) begin
      errors++;
      $display("FAIL %s_reach_handler in_handler=%b expected 1", tag, in_handler);
    end
  endtask

  task automatic test_reset();
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_tick();
    checks++;
    if ({flush, pc_redirect, in_handler, double_fault} !== 4'b0 || redirect_pc !== 32'h0 ||
        epc !== 32'h0 || cause !== 4'h0 || exc_count !== 8'h0) begin
      errors++;
      $display("FAIL reset_state fl=%b pr=%b ih=%b df=%b rpc=%h epc=%h cause=%0d cnt=%0d expected all 0",
               flush, pc_redirect, in_handler, double_fault, redirect_pc, epc, cause, exc_count);
    end
  endtask

  task automatic test_no_fault();
    tick(1'b1, 8'h81, 32'h0000_0400, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL nofault_mem_read got %b expected 1", mem_read); end
    idle_tick();
    checks++;
    if (flush !== 1'b0 || exc_count !== 8'd0) begin
      errors++; $display("FAIL nofault_state flush=%b cnt=%0d expected 0/0", flush, exc_count);
    end
  endtask

  task automatic test_overflow_return();
    logic [3:0] fl;
    tick(1'b1, 8'h4C, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL ovf_gate mem_write=%b expected 0", mem_write); end
    idle_tick();
    checks++;
    if (epc !== 32'h1000 || cause !== 4'd1) begin
      errors++; $display("FAIL ovf_latch epc=%h cause=%0d expected 1000/1", epc, cause);
    end
    fl[0] = flush;
    idle_tick(); fl[1] = flush;
    idle_tick(); fl[2] = flush;
    checks++;
    if (fl[2:0] !== 3'b011 || pc_redirect !== 1'b1 || redirect_pc !== 32'h80) begin
      errors++; $display("FAIL ovf_flush_redirect flush_seq=%b pr=%b rpc=%h expected 011/1/80",
                         fl[2:0], pc_redirect, redirect_pc);
    end
    idle_tick();
    checks++;
    if (in_handler !== 1'b1 || pc_redirect !== 1'b0) begin
      errors++; $display("FAIL ovf_handler ih=%b pr=%b expected 1/0", in_handler, pc_redirect);
    end
    tick(1'b1, 8'h00, 32'h0000_0090, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_tick();
    checks++;
    if (pc_redirect !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h1004) begin
      errors++; $display("FAIL ret_redirect pr=%b fl=%b rpc=%h expected 1/1/1004", pc_redirect, flush, redirect_pc);
    end
    tick(1'b1, 8'h00, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc_redirect !== 1'b0 || flush !== 1'b0 || in_handler !== 1'b0 || mem_read !== 1'b1) begin
      errors++; $display("FAIL ret_idle pr=%b fl=%b ih=%b mr=%b expected 0/0/0/1",
                         pc_redirect, flush, in_handler, mem_read);
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 8'h08, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL wrap_gate mem_read=%b expected 0", mem_read); end
    wait_handler("wrap");
    tick(1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_tick();
    checks++;
    if (pc_redirect !== 1'b1 || redirect_pc !== 32'h0 || cause !== 4'd2) begin
      errors++; $display("FAIL wrap_redirect pr=%b rpc=%h cause=%0d expected 1/0/2", pc_redirect, redirect_pc, cause);
    end
    idle_tick();
  endtask

  task automatic test_double_fault();
    logic [31:0] saved;
    tick(1'b1, 8'h40, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_handler("dbl");
    saved = 32'h0000_2000;
    tick(1'b1, 8'h04, 32'h0000_0084, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL dbl_gate mr=%b mw=%b expected 0/0", mem_read, mem_write);
    end
    idle_tick();
    checks++;
    if (double_fault !== 1'b1 || cause !== 4'd3 || epc !== saved || flush !== 1'b1 ||
        in_handler !== 1'b0 || pc_redirect !== 1'b0) begin
      errors++; $display("FAIL dbl_enter df=%b cause=%0d epc=%h fl=%b ih=%b pr=%b expected 1/3/%h/1/0/0",
                         double_fault, cause, epc, flush, in_handler, pc_redirect, saved);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (flush !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || pc_redirect !== 1'b0) begin
        errors++; $display("FAIL dbl_halt[%0d] fl=%b mr=%b mw=%b pr=%b expected 1/0/0/0",
                           i, flush, mem_read, mem_write, pc_redirect);
      end
    end
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_tick();
    checks++;
    if ({flush, pc_redirect, in_handler, double_fault} !== 4'b0 || redirect_pc !== 32'h0 ||
        epc !== 32'h0 || cause !== 4'h0 || exc_count !== 8'h0) begin
      errors++; $display("FAIL dbl_reset fl=%b pr=%b ih=%b df=%b rpc=%h epc=%h cause=%0d cnt=%0d expected all 0",
                         flush, pc_redirect, in_handler, double_fault, redirect_pc, epc, cause, exc_count);
    end
  endtask

  task automatic test_gating();
    tick(1'b0, 8'h40, 32'h0000_3000, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b1) begin
      errors++; $display("FAIL gate_invalid mr=%b mw=%b expected 1/1", mem_read, mem_write);
    end
    idle_tick();
    checks++;
    if (flush !== 1'b0 || exc_count !== 8'd0 || epc !== 32'h0) begin
      errors++; $display("FAIL gate_nofault fl=%b cnt=%0d epc=%h expected 0/0/0", flush, exc_count, epc);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      tick(1'b1, 8'h40, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && !in_handler; i++) idle_tick();
      tick(1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle_tick();
    end
    idle_tick();
    checks++;
    if (exc_count !== 8'd255 || m_cnt != 255) begin
      errors++; $display("FAIL saturate exc_count=%0d model=%0d expected 255", exc_count, m_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] st;
    tick(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (8'($urandom) & 8'hB3);
      tick(($urandom_range(0, 3) != 0), st, 32'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
      checks++;
      if (flush !== e_flush || pc_redirect !== e_redir || redirect_pc !== e_rpc ||
          in_handler !== e_inh || mem_read !== e_mr || mem_write !== e_mw ||
          epc !== m_epc || cause !== m_cause || exc_count !== 8'(m_cnt) || double_fault !== m_dbl) begin
        errors++;
        $display("FAIL random[%0d] got fl=%b pr=%b rpc=%h ih=%b mr=%b mw=%b epc=%h c=%0d n=%0d df=%b expected fl=%b pr=%b rpc=%h ih=%b mr=%b mw=%b epc=%h c=%0d n=%0d df=%b",
                 n, flush, pc_redirect, redirect_pc, in_handler, mem_read, mem_write, epc, cause, exc_count, double_fault,
                 e_flush, e_redir, e_rpc, e_inh, e_mr, e_mw, m_epc, m_cause, m_cnt, m_dbl);
      end
    end
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; alu_status = 8'h00; ex_pc = 32'h0;
    mem_read_req = 1'b0; mem_write_req = 1'b0; eret = 1'b0;
    test_reset();
    test_no_fault();
    test_overflow_return();
    test_wrap();
    test_double_fault();
    test_gating();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
